// File: rtl/ifetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_stage
// Brief    : miniLA instruction fetch stage; owns the PC, fetches over a
//            req/ack memory port and holds one instruction for decode.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst,
    output logic [31:0]      pc,
    output logic [31:0]      pc4,
    output logic             inst_valid,
    input  logic             inst_ready,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    input  logic             flush,
    input  logic [31:0]      flush_pc,
    output logic             fetch_err,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_REQ  = 3'd1;
    localparam logic [2:0] c_DROP = 3'd2;
    localparam logic [2:0] c_HOLD = 3'd3;
    localparam logic [2:0] c_ERR  = 3'd4;

    logic [2:0]       r_state;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_pend_pc;
    logic [31:0]      r_inst;
    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_fetch_cnt;

    logic [2:0]  w_state_nxt;
    logic [31:0] w_target;
    logic        w_load_fpc;
    logic        w_load_pend;
    logic        w_load_inst;
    logic        w_cnt_inc;
    logic [2:0]  w_go;

    // Every new fetch address lands in REQ unless it is misaligned
    assign w_go = (w_target[1:0] == 2'b00) ? c_REQ : c_ERR;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_target    = r_fetch_pc;
        w_load_fpc  = 1'b0;
        w_load_pend = 1'b0;
        w_load_inst = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            c_IDLE: w_state_nxt = c_REQ;
            c_REQ: begin
                if (flush) begin
                    w_target = flush_pc;
                    if (imem_ack) begin
                        w_load_fpc  = 1'b1;
                        w_state_nxt = w_go;
                    end else begin
                        w_load_pend = 1'b1;
                        w_state_nxt = c_DROP;
                    end
                end else if (imem_ack) begin
                    w_load_inst = 1'b1;
                    w_state_nxt = c_HOLD;
                end
            end
            c_DROP: begin
                // A flush arriving with the ack still wins as the target
                w_target = flush ? flush_pc : r_pend_pc;
                if (imem_ack) begin
                    w_load_fpc  = 1'b1;
                    w_state_nxt = w_go;
                end else if (flush) begin
                    w_load_pend = 1'b1;
                end
            end
            c_HOLD: begin
                if (flush) begin
                    w_target    = flush_pc;
                    w_load_fpc  = 1'b1;
                    w_state_nxt = w_go;
                end else if (inst_ready) begin
                    w_target    = redirect ? redirect_pc : r_pc + 32'd4;
                    w_load_fpc  = 1'b1;
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = w_go;
                end
            end
            c_ERR: begin
                w_target = flush_pc;
                if (flush && (flush_pc[1:0] == 2'b00)) begin
                    w_load_fpc  = 1'b1;
                    w_state_nxt = c_REQ;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc  <= RESET_PC;
            r_pend_pc   <= RESET_PC;
            r_inst      <= 32'd0;
            r_pc        <= 32'd0;
            r_fetch_cnt <= '0;
        end else begin
            if (w_load_fpc) begin
                r_fetch_pc <= w_target;
            end
            if (w_load_pend) begin
                r_pend_pc <= w_target;
            end
            if (w_load_inst) begin
                r_inst <= imem_rdata;
                r_pc   <= r_fetch_pc;
            end
            if (w_cnt_inc) begin
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        imem_req   = (r_state == c_REQ) || (r_state == c_DROP);
        inst_valid = (r_state == c_HOLD);
        fetch_err  = (r_state == c_ERR);
    end

    assign imem_addr = r_fetch_pc;
    assign inst      = r_inst;
    assign pc        = r_pc;
    assign pc4       = r_pc + 32'd4;
    assign fetch_cnt = r_fetch_cnt;

endmodule
`default_nettype wire
